// File: rtl/alu.sv
// 16-bit integer ALU for the execute stage.
// Result and flag vector are registered: operands and opcode presented before a
// rising edge produce c/flags valid just after that edge. A new operation is
// accepted every cycle; there is no handshake and no other internal state.
// Flag vector layout: [0]=C carry/borrow, [1]=F signed overflow,
// [2]=L unsigned less, [3]=N negative / signed less, [4]=Z zero.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  opcode,
  input  logic        c_in,
  output logic [15:0] c,
  output logic [4:0]  flags
);

  // Opcode encodings; 12..15 fall through to the NOP behaviour.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_RSHL = 4'd10;
  localparam logic [3:0] OP_RSHA = 4'd11;

  // Bit positions inside the flag vector.
  localparam int FLAG_C = 0;
  localparam int FLAG_F = 1;
  localparam int FLAG_L = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 4;

  logic [15:0] c_q, c_d;
  logic [4:0]  flags_q, flags_d;

  logic        add_cin;
  logic [16:0] add_sum;
  logic [16:0] sub_diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        set_nz;

  // Shared arithmetic: one 17-bit adder (carry-in only for ADDC) and one
  // 17-bit subtractor whose top bit is the borrow.
  always_comb begin
    add_cin  = (opcode == OP_ADDC) ? c_in : 1'b0;
    add_sum  = {1'b0, a} + {1'b0, b} + {16'd0, add_cin};
    sub_diff = {1'b0, a} - {1'b0, b};
    // Overflow when both operands share a sign the result does not have.
    add_ovf  = (~a[15] & ~b[15] &  add_sum[15]) | (a[15] &  b[15] & ~add_sum[15]);
    // Overflow when operand signs differ and the result takes b's sign.
    sub_ovf  = (~a[15] &  b[15] & sub_diff[15]) | (a[15] & ~b[15] & ~sub_diff[15]);
  end

  // Result and flag selection; any flag an operation does not own stays 0.
  always_comb begin
    c_d     = 16'h0000;
    flags_d = 5'b00000;
    set_nz  = 1'b0;
    unique case (opcode)
      OP_ADD, OP_ADDC: begin
        c_d             = add_sum[15:0];
        flags_d[FLAG_C] = add_sum[16];
        flags_d[FLAG_F] = add_ovf;
        set_nz          = 1'b1;
      end
      OP_SUB: begin
        c_d             = sub_diff[15:0];
        flags_d[FLAG_C] = sub_diff[16];
        flags_d[FLAG_F] = sub_ovf;
        set_nz          = 1'b1;
      end
      OP_CMP: begin
        // Result is discarded; only the relational flags are produced.
        flags_d[FLAG_L] = (a < b);
        flags_d[FLAG_N] = ($signed(a) < $signed(b));
        flags_d[FLAG_Z] = (a == b);
      end
      OP_AND: begin
        c_d    = a & b;
        set_nz = 1'b1;
      end
      OP_OR: begin
        c_d    = a | b;
        set_nz = 1'b1;
      end
      OP_XOR: begin
        c_d    = a ^ b;
        set_nz = 1'b1;
      end
      OP_NOT: begin
        c_d    = ~a;
        set_nz = 1'b1;
      end
      OP_LSH: begin
        c_d             = {a[14:0], 1'b0};
        flags_d[FLAG_C] = a[15];
        set_nz          = 1'b1;
      end
      OP_RSHL: begin
        c_d             = {1'b0, a[15:1]};
        flags_d[FLAG_C] = a[0];
        set_nz          = 1'b1;
      end
      OP_RSHA: begin
        c_d             = {a[15], a[15:1]};
        flags_d[FLAG_C] = a[0];
        set_nz          = 1'b1;
      end
      default: begin
        // NOP and the unused encodings: zero result, all flags clear.
        c_d     = 16'h0000;
        flags_d = 5'b00000;
      end
    endcase
    if (set_nz) begin
      flags_d[FLAG_N] = c_d[15];
      flags_d[FLAG_Z] = (c_d == 16'h0000);
    end
  end

  // Output register; reset clears result and flags without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= 16'h0000;
      flags_q <= 5'b00000;
    end else begin
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign c     = c_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary cases, asynchronous reset
// behaviour, and randomized vectors against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  opcode;
  logic        c_in;
  logic [15:0] c;
  logic [4:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .c_in   (c_in),
    .c      (c),
    .flags  (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic on unsigned/signed values.
  // Flags returned as Z*16 + N*8 + L*4 + F*2 + C.
  function automatic void ref_model(input int op, input int ua, input int ub, input int ci,
                                    output int r, output int fl);
    int sa, sb, s, sr, q;
    int fc, ff, flt, fn, fz;
    bit nz;
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 0; fc = 0; ff = 0; flt = 0; fn = 0; fz = 0; nz = 0;
    case (op)
      1, 2: begin
        s  = ua + ub + ((op == 2) ? ci : 0);
        sr = sa + sb + ((op == 2) ? ci : 0);
        r  = s % 65536;
        fc = (s >= 65536) ? 1 : 0;
        ff = (sr > 32767 || sr < -32768) ? 1 : 0;
        nz = 1;
      end
      3: begin
        s  = ua - ub;
        sr = sa - sb;
        r  = (s + 65536) % 65536;
        fc = (ua < ub) ? 1 : 0;
        ff = (sr > 32767 || sr < -32768) ? 1 : 0;
        nz = 1;
      end
      4: begin
        flt = (ua < ub) ? 1 : 0;
        fn  = (sa < sb) ? 1 : 0;
        fz  = (ua == ub) ? 1 : 0;
      end
      5: begin r = ua & ub; nz = 1; end
      6: begin r = ua | ub; nz = 1; end
      7: begin r = ua ^ ub; nz = 1; end
      8: begin r = 65535 - ua; nz = 1; end
      9: begin r = (ua * 2) % 65536; fc = (ua >= 32768) ? 1 : 0; nz = 1; end
      10: begin r = ua / 2; fc = ua % 2; nz = 1; end
      11: begin
        q  = (sa - (ua % 2)) / 2;   // floor(sa/2)
        r  = (q + 65536) % 65536;
        fc = ua % 2;
        nz = 1;
      end
      default: ;
    endcase
    if (nz) begin
      fn = (r >= 32768) ? 1 : 0;
      fz = (r == 0) ? 1 : 0;
    end
    fl = fz * 16 + fn * 8 + flt * 4 + ff * 2 + fc;
  endfunction

  // Present one operation and wait until just after the edge that registers it.
  task automatic issue(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                       input logic ci);
    opcode = op; a = va; b = vb; c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    opcode = 4'd1; a = 16'h0001; b = 16'h0001; c_in = 1'b0;
    #2;
    n_tests++;
    if (c !== 16'h0000 || flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_initial: c=%h flags=%b, expected c=0000 flags=00000", c, flags);
    end
    @(posedge clk); #1;
    n_tests++;
    if (c !== 16'h0000 || flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_held: c=%h flags=%b, expected c=0000 flags=00000", c, flags);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (c !== 16'h0002 || flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_release: c=%h flags=%b, expected c=0002 flags=00000", c, flags);
    end
    // Mid-cycle assertion must clear outputs without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (c !== 16'h0000 || flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_async: c=%h flags=%b, expected c=0000 flags=00000", c, flags);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (c !== 16'h0002) begin
      n_fail++;
      $display("FAIL reset_rerelease: c=%h, expected c=0002", c);
    end
  endtask

  // Directed boundary vectors: {opcode, a, b, c_in, expected c, expected flags ZNLFC}.
  task automatic test_directed;
    logic [3:0]  t_op [16];
    logic [15:0] t_a  [16];
    logic [15:0] t_b  [16];
    logic        t_ci [16];
    logic [15:0] t_c  [16];
    logic [4:0]  t_f  [16];
    t_op[0]  = 4'd1;  t_a[0]  = 16'hFFFF; t_b[0]  = 16'h0001; t_ci[0]  = 1'b0; t_c[0]  = 16'h0000; t_f[0]  = 5'b10001;
    t_op[1]  = 4'd1;  t_a[1]  = 16'h7FFF; t_b[1]  = 16'h0001; t_ci[1]  = 1'b1; t_c[1]  = 16'h8000; t_f[1]  = 5'b01010;
    t_op[2]  = 4'd2;  t_a[2]  = 16'h7FFF; t_b[2]  = 16'h0000; t_ci[2]  = 1'b1; t_c[2]  = 16'h8000; t_f[2]  = 5'b01010;
    t_op[3]  = 4'd3;  t_a[3]  = 16'h0000; t_b[3]  = 16'h0001; t_ci[3]  = 1'b0; t_c[3]  = 16'hFFFF; t_f[3]  = 5'b01001;
    t_op[4]  = 4'd3;  t_a[4]  = 16'h8000; t_b[4]  = 16'h0001; t_ci[4]  = 1'b1; t_c[4]  = 16'h7FFF; t_f[4]  = 5'b00010;
    t_op[5]  = 4'd4;  t_a[5]  = 16'h0001; t_b[5]  = 16'hFFFF; t_ci[5]  = 1'b0; t_c[5]  = 16'h0000; t_f[5]  = 5'b00100;
    t_op[6]  = 4'd4;  t_a[6]  = 16'hFFFF; t_b[6]  = 16'h0001; t_ci[6]  = 1'b0; t_c[6]  = 16'h0000; t_f[6]  = 5'b01000;
    t_op[7]  = 4'd4;  t_a[7]  = 16'h1234; t_b[7]  = 16'h1234; t_ci[7]  = 1'b1; t_c[7]  = 16'h0000; t_f[7]  = 5'b10000;
    t_op[8]  = 4'd5;  t_a[8]  = 16'hF0F0; t_b[8]  = 16'h0FF0; t_ci[8]  = 1'b0; t_c[8]  = 16'h00F0; t_f[8]  = 5'b00000;
    t_op[9]  = 4'd8;  t_a[9]  = 16'h0000; t_b[9]  = 16'h1234; t_ci[9]  = 1'b0; t_c[9]  = 16'hFFFF; t_f[9]  = 5'b01000;
    t_op[10] = 4'd9;  t_a[10] = 16'h8001; t_b[10] = 16'hFFFF; t_ci[10] = 1'b0; t_c[10] = 16'h0002; t_f[10] = 5'b00001;
    t_op[11] = 4'd10; t_a[11] = 16'h8001; t_b[11] = 16'h0000; t_ci[11] = 1'b1; t_c[11] = 16'h4000; t_f[11] = 5'b00001;
    t_op[12] = 4'd11; t_a[12] = 16'h8001; t_b[12] = 16'h0000; t_ci[12] = 1'b0; t_c[12] = 16'hC000; t_f[12] = 5'b01001;
    t_op[13] = 4'd0;  t_a[13] = 16'h0000; t_b[13] = 16'h0000; t_ci[13] = 1'b1; t_c[13] = 16'h0000; t_f[13] = 5'b00000;
    t_op[14] = 4'd6;  t_a[14] = 16'h0000; t_b[14] = 16'h0000; t_ci[14] = 1'b0; t_c[14] = 16'h0000; t_f[14] = 5'b10000;
    t_op[15] = 4'd7;  t_a[15] = 16'hA5A5; t_b[15] = 16'h0FF0; t_ci[15] = 1'b0; t_c[15] = 16'hAA55; t_f[15] = 5'b01000;
    for (int i = 0; i < 16; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_ci[i]);
      n_tests++;
      if (c !== t_c[i] || flags !== t_f[i]) begin
        n_fail++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h ci=%b: c=%h flags=%b, expected c=%h flags=%b",
                 i, t_op[i], t_a[i], t_b[i], t_ci[i], c, flags, t_c[i], t_f[i]);
      end
    end
  endtask

  // 1000 random vectors per opcode (including NOP and 12..15), one check per cycle.
  task automatic test_random_per_op;
    int r, fl;
    logic [15:0] va, vb, exp_c;
    logic [4:0]  exp_f;
    logic        ci;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 1000; k++) begin
        va = 16'($urandom); vb = 16'($urandom); ci = 1'($urandom);
        ref_model(op, int'(va), int'(vb), int'(ci), r, fl);
        exp_c = r[15:0]; exp_f = fl[4:0];
        issue(4'(op), va, vb, ci);
        n_tests++;
        if (c !== exp_c || flags !== exp_f) begin
          n_fail++;
          $display("FAIL random op=%0d a=%h b=%h ci=%b: c=%h flags=%b, expected c=%h flags=%b",
                   op, va, vb, ci, c, flags, exp_c, exp_f);
        end
      end
    end
  endtask

  // Mixed opcodes every cycle, biased toward boundary operand values.
  task automatic test_back_to_back;
    int r, fl;
    logic [15:0] va, vb, exp_c;
    logic [4:0]  exp_f;
    logic [3:0]  op;
    logic        ci;
    logic [15:0] edges [6];
    edges[0] = 16'h0000; edges[1] = 16'h0001; edges[2] = 16'h7FFF;
    edges[3] = 16'h8000; edges[4] = 16'hFFFF; edges[5] = 16'h8001;
    for (int k = 0; k < 600; k++) begin
      op = 4'($urandom);
      va = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      vb = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      ci = 1'($urandom);
      ref_model(int'(op), int'(va), int'(vb), int'(ci), r, fl);
      exp_c = r[15:0]; exp_f = fl[4:0];
      issue(op, va, vb, ci);
      n_tests++;
      if (c !== exp_c || flags !== exp_f) begin
        n_fail++;
        $display("FAIL back_to_back op=%0d a=%h b=%h ci=%b: c=%h flags=%b, expected c=%h flags=%b",
                 op, va, vb, ci, c, flags, exp_c, exp_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_per_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
